// File: rtl/ov5647_cfg_sequencer_if.sv
// SCCB write-engine handshake: one register write {regah, regal, value} per send/taken exchange.
interface ov5647_cfg_sequencer_if;
   logic       send;
   logic       waitnull;
   logic [7:0] regah;
   logic [7:0] regal;
   logic [7:0] value;
   logic       taken;

   modport master (output send, waitnull, regah, regal, value, input taken);
   modport slave  (input send, waitnull, regah, regal, value, output taken);
endinterface

// File: rtl/ov5647_cfg_sequencer.sv
// OV5647 init-table sequencer: waits out the power-up settle time, then walks the register ROM,
// handing each write to the SCCB engine and honouring in-table ms delays and the terminator.
module ov5647_cfg_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int MS_CYCLES  = 50000,
   parameter int TXN_CYCLES = 10496,
   parameter int BOOT_MS    = 20
) (
   input  logic                   clk,
   input  logic                   resend,
   input  logic                   start,
   output logic [ADDR_W-1:0]      rom_addr,
   input  logic [23:0]            rom_data,
   ov5647_cfg_sequencer_if.master sccb,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int PRE_W = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
   localparam int GRD_W = $clog2(TXN_CYCLES + 1);

   typedef enum logic [2:0] {
      S_BOOT, S_FETCH, S_DECODE, S_SEND, S_DRAIN, S_DELAY, S_DONE
   } state_t;

   state_t            r_state;
   logic [PRE_W-1:0]  r_pre;
   logic [7:0]        r_ms;
   logic [GRD_W-1:0]  r_guard;
   logic              r_drain_to_delay;
   logic [ADDR_W-1:0] r_rom_addr;
   logic              r_send;
   logic              r_waitnull;
   logic [7:0]        r_regah;
   logic [7:0]        r_regal;
   logic [7:0]        r_value;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [15:0]       w_key;

   assign w_key = rom_data[23:8];

   always_ff @(posedge clk or posedge resend) begin
      if (resend) begin
         r_state          <= S_BOOT;
         r_pre            <= '0;
         r_ms             <= '0;
         r_guard          <= '0;
         r_drain_to_delay <= 1'b0;
         r_rom_addr       <= '0;
         r_send           <= 1'b0;
         r_waitnull       <= 1'b1;
         r_regah          <= '0;
         r_regal          <= '0;
         r_value          <= '0;
         r_busy           <= 1'b1;
         r_done           <= 1'b0;
         r_err            <= 1'b0;
      end else begin
         // Bus guard runs in every state; SEND reloads it after each accepted write.
         if (r_guard != '0) r_guard <= r_guard - GRD_W'(1);

         case (r_state)
            S_BOOT: begin
               if (r_pre == PRE_W'(MS_CYCLES - 1)) begin
                  r_pre <= '0;
                  if (r_ms == 8'(BOOT_MS - 1)) begin
                     r_ms    <= '0;
                     r_state <= S_FETCH;
                  end else begin
                     r_ms <= r_ms + 8'd1;
                  end
               end else begin
                  r_pre <= r_pre + PRE_W'(1);
               end
            end

            S_FETCH: r_state <= S_DECODE;

            S_DECODE: begin
               if (w_key == 16'hFFFF) begin
                  r_drain_to_delay <= 1'b0;
                  r_state          <= S_DRAIN;
               end else if (w_key == 16'hFFFE) begin
                  r_ms             <= rom_data[7:0];
                  r_pre            <= '0;
                  r_drain_to_delay <= 1'b1;
                  r_state          <= S_DRAIN;
               end else begin
                  r_regah    <= rom_data[23:16];
                  r_regal    <= rom_data[15:8];
                  r_value    <= rom_data[7:0];
                  r_send     <= 1'b1;
                  r_waitnull <= 1'b0;
                  r_state    <= S_SEND;
               end
            end

            S_SEND: begin
               if (sccb.taken) begin
                  r_send     <= 1'b0;
                  r_waitnull <= 1'b1;
                  r_guard    <= GRD_W'(TXN_CYCLES);
                  r_rom_addr <= r_rom_addr + ADDR_W'(1);
                  if (&r_rom_addr) begin
                     r_err            <= 1'b1;
                     r_drain_to_delay <= 1'b0;
                     r_state          <= S_DRAIN;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end

            S_DRAIN: begin
               if (r_guard == '0) begin
                  if (r_drain_to_delay) begin
                     r_state <= S_DELAY;
                  end else begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_DONE;
                  end
               end
            end

            S_DELAY: begin
               if (r_ms == 8'd0) begin
                  r_rom_addr <= r_rom_addr + ADDR_W'(1);
                  r_state    <= S_FETCH;
               end else if (r_pre == PRE_W'(MS_CYCLES - 1)) begin
                  r_pre <= '0;
                  r_ms  <= r_ms - 8'd1;
                  if (r_ms == 8'd1) begin
                     r_rom_addr <= r_rom_addr + ADDR_W'(1);
                     r_state    <= S_FETCH;
                  end
               end else begin
                  r_pre <= r_pre + PRE_W'(1);
               end
            end

            S_DONE: begin
               if (start) begin
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_busy     <= 1'b1;
                  r_rom_addr <= '0;
                  r_state    <= S_FETCH;
               end
            end

            default: r_state <= S_BOOT;
         endcase
      end
   end

   assign rom_addr      = r_rom_addr;
   assign sccb.send     = r_send;
   assign sccb.waitnull = r_waitnull;
   assign sccb.regah    = r_regah;
   assign sccb.regal    = r_regal;
   assign sccb.value    = r_value;
   assign busy          = r_busy;
   assign done          = r_done;
   assign err           = r_err;

endmodule

// File: tb/tb_ov5647_cfg_sequencer.sv
// Bench for ov5647_cfg_sequencer: ROM and SCCB-engine models, scoreboard of expected sends and done events.
`timescale 1ns/1ps
module tb_ov5647_cfg_sequencer;
   localparam int AW = 2, MS = 10, TXN = 50, BOOT = 2;

   logic          clk = 1'b0;
   logic          resend = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] rom_addr;
   logic [23:0]   rom_data;
   logic          busy, done, err;

   ov5647_cfg_sequencer_if sif ();

   ov5647_cfg_sequencer #(
      .ADDR_W(AW), .MS_CYCLES(MS), .TXN_CYCLES(TXN), .BOOT_MS(BOOT)
   ) dut (
      .clk(clk), .resend(resend), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .sccb(sif.master), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [23:0] rom [4];
   always @(posedge clk) rom_data <= rom[rom_addr];

   // SCCB engine model: taken pulses one clk after send=1/waitnull=0 is seen
   bit model_en = 1'b1;
   bit pend = 1'b0;
   initial sif.taken = 1'b0;
   always @(negedge clk) begin
      if (sif.taken) sif.taken = 1'b0;
      else if (pend) begin sif.taken = 1'b1; pend = 1'b0; end
      else if (model_en && sif.send && !sif.waitnull) pend = 1'b1;
   end

   // rf: 0 = measured from reset release, 1 = from last taken, 2 = from start pulse
   typedef struct { logic [23:0] data; int rf; int lo; int hi; } exp_t;
   typedef struct { logic err; int lo; int hi; } dexp_t;
   exp_t  sq[$];
   dexp_t dq[$];

   int n_cmp = 0, n_bad = 0;
   int t_rst = 0, t_start = 0, t_taken = 0, n_taken = 0;
   logic [23:0] cur_data = '0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_rng(string nm, int act, int lo, int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d..%0d (cyc %0d)", nm, act, lo, hi, cyc);
      end
   endtask

   // Monitor: pops expectations whenever send or done rises
   logic  send_q = 1'b0, done_q = 1'b0;
   exp_t  me;
   dexp_t md;
   int    mref;
   always @(negedge clk) begin
      #2;
      if (sif.taken) begin
         check("bytes_at_taken", {8'h0, sif.regah, sif.regal, sif.value}, {8'h0, cur_data});
         t_taken = cyc;
         n_taken++;
      end
      if (sif.send && !send_q) begin
         if (sq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_send: got %06h expected none", {sif.regah, sif.regal, sif.value});
         end else begin
            me = sq.pop_front();
            mref = (me.rf == 0) ? t_rst : (me.rf == 1) ? t_taken : t_start;
            cur_data = me.data;
            check("send_bytes", {8'h0, sif.regah, sif.regal, sif.value}, {8'h0, me.data});
            check_rng("send_gap", cyc - mref, me.lo, me.hi);
         end
      end
      if (done && !done_q) begin
         if (dq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got 1 expected 0");
         end else begin
            md = dq.pop_front();
            check("done_err", {31'h0, err}, {31'h0, md.err});
            check_rng("done_gap", cyc - t_taken, md.lo, md.hi);
         end
      end
      send_q = sif.send;
      done_q = done;
   end

   task automatic wait_done(int lim);
      int k = 0;
      while (done !== 1'b1 && k < lim) begin @(negedge clk); k++; end
      #3;
      check("done_reached", {31'h0, done}, 32'h1);
   endtask

   task automatic wait_send(int lim);
      int k = 0;
      while (sif.send !== 1'b1 && k < lim) begin @(negedge clk); k++; end
      #3;
      check("send_reached", {31'h0, sif.send}, 32'h1);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      t_start = cyc;
      @(negedge clk);
      start = 1'b0;
      #3;
      check("start_done_clr", {31'h0, done}, 32'h0);
      check("start_addr0", {30'h0, rom_addr}, 32'h0);
      check("start_busy", {31'h0, busy}, 32'h1);
   endtask

   task automatic load(logic [23:0] a, logic [23:0] b, logic [23:0] c, logic [23:0] d);
      rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Single write then terminator, from reset
      load(24'h010000, 24'hFFFF00, 24'h0, 24'h0);
      repeat (3) @(negedge clk);
      #3;
      check("rst_send", {31'h0, sif.send}, 32'h0);
      check("rst_waitnull", {31'h0, sif.waitnull}, 32'h1);
      check("rst_addr", {30'h0, rom_addr}, 32'h0);
      check("rst_bytes", {8'h0, sif.regah, sif.regal, sif.value}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h1);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      sq.push_back('{24'h010000, 0, 22, 22});
      dq.push_back('{1'b0, 50, 60});
      n_taken = 0;
      @(negedge clk);
      resend = 1'b0;
      t_rst = cyc;
      #3;
      check("busy_after_rst", {31'h0, busy}, 32'h1);
      wait_done(200);
      check("t1_taken_cnt", n_taken, 1);
      check("t1_queue_empty", sq.size(), 0);

      // Delay marker between two writes
      load(24'h010301, 24'hFFFE05, 24'h010001, 24'hFFFF00);
      sq.push_back('{24'h010301, 2, 3, 3});
      sq.push_back('{24'h010001, 1, 100, 110});
      dq.push_back('{1'b0, 50, 60});
      n_taken = 0;
      pulse_start();
      wait_done(400);
      check("t2_taken_cnt", n_taken, 2);
      check("t2_queue_empty", sq.size(), 0);

      // Three back-to-back writes, with an ignored start while the first is held in SEND
      load(24'h123456, 24'hABCDEF, 24'h0A0B0C, 24'hFFFF00);
      sq.push_back('{24'h123456, 2, 3, 3});
      sq.push_back('{24'hABCDEF, 1, 3, 3});
      sq.push_back('{24'h0A0B0C, 1, 3, 3});
      dq.push_back('{1'b0, 50, 60});
      n_taken = 0;
      model_en = 1'b0;
      pulse_start();
      wait_send(10);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      check("ign_start_send", {31'h0, sif.send}, 32'h1);
      check("ign_start_addr", {30'h0, rom_addr}, 32'h0);
      check("ign_start_regah", {24'h0, sif.regah}, 32'h12);
      check("ign_start_done", {31'h0, done}, 32'h0);
      model_en = 1'b1;
      wait_done(300);
      check("t3_taken_cnt", n_taken, 3);
      check("t3_queue_empty", sq.size(), 0);

      // Table overrun: four writes, no terminator
      load(24'h112233, 24'h445566, 24'h778899, 24'h0A0B0C);
      sq.push_back('{24'h112233, 2, 3, 3});
      sq.push_back('{24'h445566, 1, 3, 3});
      sq.push_back('{24'h778899, 1, 3, 3});
      sq.push_back('{24'h0A0B0C, 1, 3, 3});
      dq.push_back('{1'b1, 50, 60});
      n_taken = 0;
      pulse_start();
      wait_done(300);
      check("t4_taken_cnt", n_taken, 4);
      check("t4_err", {31'h0, err}, 32'h1);
      check("t4_queue_empty", sq.size(), 0);

      // Reset while a write is being offered
      load(24'h010000, 24'hFFFF00, 24'h0, 24'h0);
      model_en = 1'b0;
      sq.push_back('{24'h010000, 2, 3, 3});
      pulse_start();
      wait_send(10);
      @(negedge clk);
      #1 resend = 1'b1;
      #1;
      check("mid_rst_send", {31'h0, sif.send}, 32'h0);
      check("mid_rst_waitnull", {31'h0, sif.waitnull}, 32'h1);
      check("mid_rst_addr", {30'h0, rom_addr}, 32'h0);
      check("mid_rst_busy", {31'h0, busy}, 32'h1);
      check("mid_rst_regah", {24'h0, sif.regah}, 32'h0);
      sq.push_back('{24'h010000, 0, 22, 22});
      dq.push_back('{1'b0, 50, 60});
      n_taken = 0;
      model_en = 1'b1;
      @(negedge clk);
      resend = 1'b0;
      t_rst = cyc;
      wait_done(200);
      check("t5_taken_cnt", n_taken, 1);
      check("t5_queue_empty", sq.size(), 0);
      check("t5_done_queue_empty", dq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
